// File: rtl/seq_sub_cmp_pkg.sv
// Shared types and elaboration helpers for the multi-cycle subtractor/comparator.
package seq_sub_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int beats(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage : seq_sub_cmp_pkg

// File: rtl/seq_sub_cmp_sub_chunk.sv
// Combinational CHUNK-bit ripple subtractor built from full-subtractor cells.
module sub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a_k,
   input  logic [CHUNK-1:0] b_k,
   input  logic             bin,
   output logic [CHUNK-1:0] d_k,
   output logic             bout
);

   logic [CHUNK:0] bchain;

   assign bchain[0] = bin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fs
      // Borrow out when b plus the incoming borrow exceeds a for this bit.
      assign d_k[i]       = a_k[i] ^ b_k[i] ^ bchain[i];
      assign bchain[i+1]  = (~a_k[i] & b_k[i]) | (~(a_k[i] ^ b_k[i]) & bchain[i]);
   end

   assign bout = bchain[CHUNK];

endmodule : sub_chunk

// File: rtl/seq_sub_cmp.sv
// Multi-cycle A - B subtractor/comparator, CHUNK bits per beat, valid/ready on both sides.
module seq_sub_cmp
   import seq_sub_cmp_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int CHUNK  = 4,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Difference,
   output logic             Borrow,
   output logic             Overflow,
   output logic             Lt,
   output logic             Eq,
   output logic             Gt
);

   localparam int NBEATS = beats(WIDTH, CHUNK);
   localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

   if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_sub_cmp: WIDTH must be a multiple of CHUNK");
   end

   state_t            state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  diff_q, diff_d;
   logic              bin_q, bin_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              borrow_q, borrow_d;
   logic              ovf_q, ovf_d;
   logic              lt_q, lt_d;
   logic              eq_q, eq_d;
   logic              gt_q, gt_d;

   logic [CHUNK-1:0]  a_k, b_k, d_k;
   logic              bout;
   logic [WIDTH-1:0]  diff_full;
   logic              ovf_full;
   logic              lt_full;

   assign a_k = a_q[int'(cnt_q)*CHUNK +: CHUNK];
   assign b_k = b_q[int'(cnt_q)*CHUNK +: CHUNK];

   sub_chunk #(
      .CHUNK (CHUNK)
   ) u_sub_chunk (
      .a_k  (a_k),
      .b_k  (b_k),
      .bin  (bin_q),
      .d_k  (d_k),
      .bout (bout)
   );

   // Difference with the current beat's chunk merged in; complete on the last beat.
   always_comb begin
      diff_full = diff_q;
      diff_full[int'(cnt_q)*CHUNK +: CHUNK] = d_k;
   end

   assign ovf_full = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_full[WIDTH-1] != a_q[WIDTH-1]);
   assign lt_full  = SIGNED ? (diff_full[WIDTH-1] ^ ovf_full) : bout;

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      diff_d      = diff_q;
      bin_d       = bin_q;
      cnt_d       = cnt_q;
      borrow_d    = borrow_q;
      ovf_d       = ovf_q;
      lt_d        = lt_q;
      eq_d        = eq_q;
      gt_d        = gt_q;

      unique case (state_q)
         IDLE: begin
            if (InValid) begin
               a_d     = A;
               b_d     = B;
               bin_d   = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            diff_d = diff_full;
            bin_d  = bout;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) begin
               state_d  = DONE;
               cnt_d    = '0;
               borrow_d = bout;
               ovf_d    = ovf_full;
               eq_d     = (diff_full == '0);
               lt_d     = lt_full;
               gt_d     = !lt_full && (diff_full != '0);
            end
         end
         DONE: begin
            if (OutReady) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         diff_q      <= '0;
         bin_q       <= 1'b0;
         cnt_q       <= '0;
         borrow_q    <= 1'b0;
         ovf_q       <= 1'b0;
         lt_q        <= 1'b0;
         eq_q        <= 1'b0;
         gt_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         diff_q      <= diff_d;
         bin_q       <= bin_d;
         cnt_q       <= cnt_d;
         borrow_q    <= borrow_d;
         ovf_q       <= ovf_d;
         lt_q        <= lt_d;
         eq_q        <= eq_d;
         gt_q        <= gt_d;
      end
   end

   assign InReady    = (state_q == IDLE);
   assign OutValid   = out_valid_q;
   assign Difference = diff_q;
   assign Borrow     = borrow_q;
   assign Overflow   = ovf_q;
   assign Lt         = lt_q;
   assign Eq         = eq_q;
   assign Gt         = gt_q;

endmodule : seq_sub_cmp

// File: doc/seq_sub_cmp.md
Name: seq_sub_cmp

Overview:
Parametrised multi-cycle subtractor/comparator. It is the next generation of the single-bit half subtractor.
- Computes A - B over WIDTH bits, CHUNK bits per clock, and carries the borrow between beats in a register.
- Produces the difference, borrow, signed overflow and Lt/Eq/Gt flags.
- Sits between operand producers and consumers on valid/ready handshakes, trading latency for a narrow subtract datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits subtracted per beat; 1 <= CHUNK <= WIDTH.
- SIGNED, 0, comparison mode: 0 = unsigned flags, 1 = two's-complement flags.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- InValid  input  1  operands on A/B are valid.
- InReady  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- OutValid  output  1  result outputs valid.
- OutReady  input  1  consumer accepts result.
- Difference  output  WIDTH  A - B, modulo 2^WIDTH.
- Borrow  output  1  final borrow out; 1 iff A < B unsigned.
- Overflow  output  1  signed overflow of A - B; valid in both modes.
- Lt  output  1  A < B per SIGNED mode.
- Eq  output  1  A == B.
- Gt  output  1  A > B per SIGNED mode.

Behaviour:
- Constants: NBEATS = WIDTH/CHUNK. A beat counter of clog2(NBEATS) bits (minimum 1) indexes chunk k = bits [k*CHUNK +: CHUNK].
- FSM states: IDLE, RUN, DONE.
- InReady = (state == IDLE), combinational from state only. OutValid = (state == DONE), registered.
- IDLE: on InValid && InReady at edge E0:
  - capture A and B into operand registers; clear borrow reg and beat counter; go to RUN.
  - A/B are ignored at all other times.
- RUN: each edge processes one chunk:
  - {bout, dchunk} = A_k - B_k - borrow_reg.
  - Write dchunk into the Difference register chunk k; borrow_reg <= bout; counter++.
  - On the edge that processes chunk NBEATS-1, go to DONE.
- Latency: OutValid rises exactly NBEATS cycles after E0. With CHUNK = WIDTH it is 1 cycle.
- Flags are registered on the final RUN edge, from the complete result:
  - Borrow = final bout.
  - Eq = (Difference == 0).
  - Overflow = (A[MSB] != B[MSB]) && (Difference[MSB] != A[MSB]).
  - Lt = Borrow if SIGNED=0, else Difference[MSB] ^ Overflow.
  - Gt = !Lt && !Eq.
- DONE: all outputs held stable while OutReady = 0, for any number of cycles. On OutValid && OutReady, go to IDLE; InReady rises next cycle.
- No overlap: at most one operation in flight, and a new operand pair is never accepted in the DONE handshake cycle.
- Difference and flags keep their last values in IDLE and RUN; consumers sample them only while OutValid = 1.
- Reset values: state = IDLE, OutValid = 0, InReady = 1 (from state), Difference = 0, Borrow/Overflow/Lt/Eq/Gt = 0, internal registers = 0.
- Reset mid-operation (RUN or DONE): the operation is discarded, and on the next cycle the block is in the reset state. No partial result is ever flagged valid.
- rst has priority over every handshake in the same cycle.
- OutReady asserted outside DONE has no effect.

Decomposition:
- Package seq_sub_cmp_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  - function beats(width, chunk) returning width/chunk.
- Elaboration-time assertion in the block: WIDTH % CHUNK == 0.
- One sub-module, sub_chunk: purely combinational CHUNK-bit ripple subtractor (A_k, B_k, bin -> D_k, bout) built from full-subtractor cells.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- A=0x1234, B=0x0234, SIGNED=0 -> Difference=0x1000, Borrow=0, Gt=1, Lt=0, Eq=0; OutValid exactly 4 cycles after acceptance.
- A=0x0000, B=0x0001 -> Difference=0xFFFF, Borrow=1, Lt=1, Overflow=0; borrow ripples through all 4 beats.
- A=B=0xABCD -> Difference=0x0000, Eq=1, Lt=0, Gt=0, Borrow=0.
- SIGNED=1, A=0x8000, B=0x0001 -> Difference=0x7FFF, Overflow=1, Lt=1, Borrow=0. Separately A=0x0001, B=0xFFFF -> Gt=1, Borrow=1.
- OutReady held 0 for 3 cycles in DONE with InValid=1 -> outputs stable and InReady=0 throughout; after the handshake, the next pair is accepted the following cycle. Repeat with CHUNK=16: OutValid 1 cycle after acceptance.
- rst asserted after 2 RUN beats -> next cycle OutValid=0, InReady=1, Difference=0, all flags 0; the following op 0x0005-0x0003 gives 0x0002 with Gt=1.
